frame_pixel_packer: RTL and testbench



---
 rtl/frame_pixel_packer_if.sv | 26 ++
 rtl/frame_pixel_packer.sv | 194 +++++++++++++++++++
 tb/tb_frame_pixel_packer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_packer_if.sv
// Byte-stream bus into the frame pixel packer.
// Handshake: a byte moves on every rising clk edge where byte_valid and
// byte_ready are both high. byte_sof is only meaningful with byte_valid.
// The source may change byte_in/byte_sof freely while byte_valid is low.
interface frame_pixel_packer_if #(
  parameter int BYTE_W = 8
) ();
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_sof;
  logic              byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    output byte_sof,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  byte_sof,
    output byte_ready
  );
endinterface

// File: rtl/frame_pixel_packer.sv
// Frame pixel packer: assembles BYTES_PER_PX serial bytes (first byte is
// the pixel MSB) into one pixel and stores it at an auto-incrementing
// (line, pixel) position of an on-chip frame store. A start-of-frame byte
// always restarts assembly at (0,0); one seen mid-frame is flagged on
// sof_err. A registered read port returns stored pixels one cycle after
// rd_en, or zero for coordinates outside the active frame.
module frame_pixel_packer #(
  parameter int BYTE_W       = 8,
  parameter int BYTES_PER_PX = 3,
  parameter int H_ACTIVE     = 110,
  parameter int V_ACTIVE     = 110,
  parameter int POS_W        = 10,
  localparam int PX_W        = BYTE_W * BYTES_PER_PX
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_pixel_packer_if.slave  byte_if,
  output logic [POS_W-1:0]     wr_px,
  output logic [POS_W-1:0]     wr_line,
  output logic                 frame_done,
  output logic                 sof_err,
  input  logic                 rd_en,
  input  logic [POS_W-1:0]     rd_px,
  input  logic [POS_W-1:0]     rd_line,
  output logic [PX_W-1:0]      rd_data,
  output logic                 rd_valid,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  localparam int DEPTH  = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] H_LIM    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LIM    = POS_W'(V_ACTIVE);
  localparam logic [1:0]       CNT_LAST = 2'(BYTES_PER_PX - 1);

  // Frame store, line-major; deliberately has no reset.
  logic [PX_W-1:0] mem [DEPTH];

  state_t            state_q,      state_d;
  logic [1:0]        cnt_q,        cnt_d;
  logic [PX_W-1:0]   acc_q,        acc_d;
  logic [POS_W-1:0]  wr_px_q,      wr_px_d;
  logic [POS_W-1:0]  wr_line_q,    wr_line_d;
  logic              frame_done_q, frame_done_d;
  logic              sof_err_q,    sof_err_d;
  logic              ready_q;
  logic [PX_W-1:0]   rd_data_q,    rd_data_d;
  logic              rd_valid_q,   rd_valid_d;

  logic              byte_ready;
  logic              xfer;
  logic              take;
  logic [POS_W-1:0]  base_px;
  logic [POS_W-1:0]  base_line;
  logic [1:0]        base_cnt;
  logic [PX_W-1:0]   byte_ext;
  logic [PX_W-1:0]   acc_in;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [PX_W-1:0]   wdata;
  logic [ADDR_W-1:0] raddr;
  logic              rd_in_range;

  // Ready drops combinationally while reset is held so nothing is taken
  // on the reset edge itself.
  assign byte_ready         = ready_q & ~reset;
  assign byte_if.byte_ready = byte_ready;
  assign xfer               = byte_if.byte_valid & byte_ready;
  assign byte_ext           = PX_W'(byte_if.byte_in);

  // Byte acceptance, pixel assembly, store write and position advance.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    wr_px_d      = wr_px_q;
    wr_line_d    = wr_line_q;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    take         = 1'b0;
    base_px      = wr_px_q;
    base_line    = wr_line_q;
    base_cnt     = cnt_q;
    acc_in       = (acc_q << BYTE_W) | byte_ext;

    if (xfer) begin
      if (byte_if.byte_sof) begin
        // SOF discards any partial pixel and restarts at (0,0) with this
        // byte as byte 0; it also overrides completion of a last pixel.
        take      = 1'b1;
        base_px   = '0;
        base_line = '0;
        base_cnt  = '0;
        acc_in    = byte_ext;
        sof_err_d = (state_q == ST_RUN);
        state_d   = ST_RUN;
      end else if (state_q == ST_RUN) begin
        take = 1'b1;
      end
    end

    if (take) begin
      acc_d     = acc_in;
      wr_px_d   = base_px;
      wr_line_d = base_line;
      if (base_cnt == CNT_LAST) begin
        // Pixel complete: write it and step to the next position.
        we    = 1'b1;
        wdata = acc_in;
        waddr = ADDR_W'(base_line) * ADDR_W'(H_ACTIVE) + ADDR_W'(base_px);
        cnt_d = 2'd0;
        if (base_px == H_LAST) begin
          wr_px_d = '0;
          if (base_line == V_LAST) begin
            wr_line_d    = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            wr_line_d = base_line + POS_W'(1);
          end
        end else begin
          wr_px_d = base_px + POS_W'(1);
        end
      end else begin
        cnt_d = base_cnt + 2'd1;
      end
    end
  end

  // Read port: out-of-frame coordinates read as zero; data holds when idle.
  always_comb begin
    rd_in_range = (rd_line < V_LIM) && (rd_px < H_LIM);
    raddr       = ADDR_W'(rd_line) * ADDR_W'(H_ACTIVE) + ADDR_W'(rd_px);
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_in_range ? mem[raddr] : '0;
    end
  end

  // Control state, position, pulses and read registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      acc_q        <= '0;
      wr_px_q      <= '0;
      wr_line_q    <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      ready_q      <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      wr_px_q      <= wr_px_d;
      wr_line_q    <= wr_line_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      ready_q      <= 1'b1;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Store write; a read on the same edge sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign wr_px      = wr_px_q;
  assign wr_line    = wr_line_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_frame_pixel_packer.sv
// Directed bench for frame_pixel_packer: a default 3-byte 110x110 build
// and a 1-byte 4x2 build sharing one clock.
module tb_frame_pixel_packer;

  logic clk;
  logic rst_m;
  logic rst_s;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main build: 3 bytes/px, 110x110 ----------------
  frame_pixel_packer_if #(.BYTE_W(8)) bus_m ();
  logic [9:0]  wr_px_m, wr_line_m, rd_px_m, rd_line_m;
  logic        frame_done_m, sof_err_m, rd_en_m, rd_valid_m;
  logic [23:0] rd_data_m;
  logic [1:0]  state_m;

  frame_pixel_packer #(
    .BYTE_W(8), .BYTES_PER_PX(3), .H_ACTIVE(110), .V_ACTIVE(110), .POS_W(10)
  ) dut_m (
    .clk        (clk),
    .reset      (rst_m),
    .byte_if    (bus_m.slave),
    .wr_px      (wr_px_m),
    .wr_line    (wr_line_m),
    .frame_done (frame_done_m),
    .sof_err    (sof_err_m),
    .rd_en      (rd_en_m),
    .rd_px      (rd_px_m),
    .rd_line    (rd_line_m),
    .rd_data    (rd_data_m),
    .rd_valid   (rd_valid_m),
    .dbg_state  (state_m)
  );

  // ---------------- small build: 1 byte/px, 4x2 ----------------
  frame_pixel_packer_if #(.BYTE_W(8)) bus_s ();
  logic [9:0]  wr_px_s, wr_line_s, rd_px_s, rd_line_s;
  logic        frame_done_s, sof_err_s, rd_en_s, rd_valid_s;
  logic [7:0]  rd_data_s;
  logic [1:0]  state_s;

  frame_pixel_packer #(
    .BYTE_W(8), .BYTES_PER_PX(1), .H_ACTIVE(4), .V_ACTIVE(2), .POS_W(10)
  ) dut_s (
    .clk        (clk),
    .reset      (rst_s),
    .byte_if    (bus_s.slave),
    .wr_px      (wr_px_s),
    .wr_line    (wr_line_s),
    .frame_done (frame_done_s),
    .sof_err    (sof_err_s),
    .rd_en      (rd_en_s),
    .rd_px      (rd_px_s),
    .rd_line    (rd_line_s),
    .rd_data    (rd_data_s),
    .rd_valid   (rd_valid_s),
    .dbg_state  (state_s)
  );

  // ---------------- scoreboard / checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel pattern: index low byte, salt, index high byte.
  function automatic logic [23:0] pv(input int i, input logic [7:0] salt);
    logic [31:0] u;
    u = i;
    return {u[7:0], salt, u[15:8]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_m(input logic [7:0] b, input logic s);
    bus_m.byte_in    = b;
    bus_m.byte_sof   = s;
    bus_m.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_m.byte_valid = 1'b0;
    bus_m.byte_sof   = 1'b0;
  endtask

  task automatic send_px_m(input logic [23:0] v, input logic s);
    send_m(v[23:16], s);
    send_m(v[15:8], 1'b0);
    send_m(v[7:0], 1'b0);
  endtask

  task automatic rd_m(input logic [9:0] px, input logic [9:0] line);
    rd_en_m   = 1'b1;
    rd_px_m   = px;
    rd_line_m = line;
    @(posedge clk);
    #1;
    rd_en_m = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] b, input logic s);
    bus_s.byte_in    = b;
    bus_s.byte_sof   = s;
    bus_s.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_s.byte_valid = 1'b0;
    bus_s.byte_sof   = 1'b0;
  endtask

  task automatic rd_s(input logic [9:0] px, input logic [9:0] line);
    rd_en_s   = 1'b1;
    rd_px_s   = px;
    rd_line_s = line;
    @(posedge clk);
    #1;
    rd_en_s = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] v;
    bus_m.byte_in = '0; bus_m.byte_valid = 1'b0; bus_m.byte_sof = 1'b0;
    bus_s.byte_in = '0; bus_s.byte_valid = 1'b0; bus_s.byte_sof = 1'b0;
    rd_en_m = 1'b0; rd_px_m = '0; rd_line_m = '0;
    rd_en_s = 1'b0; rd_px_s = '0; rd_line_s = '0;
    rst_m = 1'b1;
    rst_s = 1'b1;

    @(posedge clk); #1;
    check_eq("rst_ready_low", 32'(bus_m.byte_ready), 0);
    @(posedge clk); #1;
    rst_m = 1'b0;
    rst_s = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready_high", 32'(bus_m.byte_ready), 1);
    check_eq("rst_wr_px", 32'(wr_px_m), 0);
    check_eq("rst_wr_line", 32'(wr_line_m), 0);
    check_eq("rst_frame_done", 32'(frame_done_m), 0);
    check_eq("rst_sof_err", 32'(sof_err_m), 0);
    check_eq("rst_rd_valid", 32'(rd_valid_m), 0);
    check_eq("rst_rd_data", 32'(rd_data_m), 0);
    check_eq("rst_state", 32'(state_m), 0);

    // Non-SOF bytes in IDLE are dropped.
    send_m(8'h55, 1'b0);
    send_m(8'h66, 1'b0);
    check_eq("idle_drop_px", 32'(wr_px_m), 0);
    check_eq("idle_drop_state", 32'(state_m), 0);

    // First pixel and read-back.
    send_px_m(24'h112233, 1'b1);
    check_eq("px0_wr_px", 32'(wr_px_m), 1);
    check_eq("px0_wr_line", 32'(wr_line_m), 0);
    check_eq("px0_state_run", 32'(state_m), 1);
    rd_m(10'd0, 10'd0);
    check_eq("rd00_valid", 32'(rd_valid_m), 1);
    check_eq("rd00_data", 32'(rd_data_m), 32'h112233);
    @(posedge clk); #1;
    check_eq("rd_idle_valid", 32'(rd_valid_m), 0);
    check_eq("rd_idle_hold", 32'(rd_data_m), 32'h112233);

    // Rest of the frame.
    for (int i = 1; i < 110 * 110; i++) begin
      send_px_m(pv(i, 8'h5A), 1'b0);
      if (i == 109) begin
        check_eq("line0_wr_line", 32'(wr_line_m), 1);
        check_eq("line0_wr_px", 32'(wr_px_m), 0);
        check_eq("line0_no_done", 32'(frame_done_m), 0);
      end
    end
    check_eq("frame_done_pulse", 32'(frame_done_m), 1);
    check_eq("frame_end_px", 32'(wr_px_m), 0);
    check_eq("frame_end_line", 32'(wr_line_m), 0);
    check_eq("frame_end_idle", 32'(state_m), 0);
    @(posedge clk); #1;
    check_eq("frame_done_single", 32'(frame_done_m), 0);
    send_m(8'h77, 1'b0);
    send_m(8'h88, 1'b0);
    send_m(8'h99, 1'b0);
    check_eq("post_frame_drop_px", 32'(wr_px_m), 0);
    check_eq("post_frame_idle", 32'(state_m), 0);
    rd_m(10'd0, 10'd0);
    check_eq("rd00_after_frame", 32'(rd_data_m), 32'h112233);
    rd_m(10'd109, 10'd0);
    check_eq("rd_109_0", 32'(rd_data_m), 32'(pv(109, 8'h5A)));
    rd_m(10'd5, 10'd0);
    check_eq("rd_5_0", 32'(rd_data_m), 32'(pv(5, 8'h5A)));
    rd_m(10'd109, 10'd109);
    check_eq("rd_last", 32'(rd_data_m), 32'(pv(12099, 8'h5A)));

    // SOF after two bytes of pixel 5.
    send_px_m(pv(0, 8'hC3), 1'b1);
    for (int i = 1; i < 5; i++) send_px_m(pv(i, 8'hC3), 1'b0);
    v = pv(5, 8'hC3);
    send_m(v[23:16], 1'b0);
    send_m(v[15:8], 1'b0);
    send_m(8'hAA, 1'b1);
    check_eq("abort_sof_err", 32'(sof_err_m), 1);
    check_eq("abort_wr_px", 32'(wr_px_m), 0);
    check_eq("abort_state", 32'(state_m), 1);
    check_eq("abort_no_done", 32'(frame_done_m), 0);
    @(posedge clk); #1;
    check_eq("abort_sof_err_single", 32'(sof_err_m), 0);
    rd_m(10'd5, 10'd0);
    check_eq("abort_px5_unwritten", 32'(rd_data_m), 32'(pv(5, 8'h5A)));
    send_m(8'hBB, 1'b0);
    // Final byte of (0,0) and a read of (0,0) on the same edge.
    bus_m.byte_in    = 8'hCC;
    bus_m.byte_valid = 1'b1;
    rd_en_m   = 1'b1;
    rd_px_m   = 10'd0;
    rd_line_m = 10'd0;
    @(posedge clk); #1;
    bus_m.byte_valid = 1'b0;
    rd_en_m = 1'b0;
    check_eq("rw_same_edge_old", 32'(rd_data_m), 32'(pv(0, 8'hC3)));
    check_eq("rw_wr_px", 32'(wr_px_m), 1);
    rd_m(10'd0, 10'd0);
    check_eq("rw_next_new", 32'(rd_data_m), 32'hAABBCC);
    rd_m(10'd110, 10'd0);
    check_eq("rd_oob_px_data", 32'(rd_data_m), 0);
    check_eq("rd_oob_px_valid", 32'(rd_valid_m), 1);
    rd_m(10'd0, 10'd110);
    check_eq("rd_oob_line_data", 32'(rd_data_m), 0);

    // ---------- small build ----------
    for (int k = 0; k < 8; k++) begin
      send_s(8'(16 + k), (k == 0));
      if (k == 2) check_eq("s_px2_wr_px", 32'(wr_px_s), 3);
      if (k == 3) begin
        check_eq("s_wrap_px", 32'(wr_px_s), 0);
        check_eq("s_wrap_line", 32'(wr_line_s), 1);
      end
      if (k == 6) check_eq("s_no_early_done", 32'(frame_done_s), 0);
    end
    check_eq("s_frame_done", 32'(frame_done_s), 1);
    check_eq("s_end_px", 32'(wr_px_s), 0);
    check_eq("s_end_line", 32'(wr_line_s), 0);
    check_eq("s_end_idle", 32'(state_s), 0);
    @(posedge clk); #1;
    check_eq("s_done_single", 32'(frame_done_s), 0);
    rd_s(10'd3, 10'd0);
    check_eq("s_rd_3_0", 32'(rd_data_s), 32'h13);
    rd_s(10'd0, 10'd1);
    check_eq("s_rd_0_1", 32'(rd_data_s), 32'h14);
    rd_s(10'd3, 10'd1);
    check_eq("s_rd_3_1", 32'(rd_data_s), 32'h17);

    // SOF coinciding with the last pixel of a frame.
    for (int k = 0; k < 7; k++) send_s(8'(32 + k), (k == 0));
    send_s(8'h27, 1'b1);
    check_eq("s_lastsof_err", 32'(sof_err_s), 1);
    check_eq("s_lastsof_no_done", 32'(frame_done_s), 0);
    check_eq("s_lastsof_px", 32'(wr_px_s), 1);
    check_eq("s_lastsof_line", 32'(wr_line_s), 0);
    check_eq("s_lastsof_run", 32'(state_s), 1);
    rd_s(10'd3, 10'd1);
    check_eq("s_lastpx_kept", 32'(rd_data_s), 32'h17);
    rd_s(10'd0, 10'd0);
    check_eq("s_sof_byte_px0", 32'(rd_data_s), 32'h27);
    rd_s(10'd2, 10'd1);
    check_eq("s_rd_2_1", 32'(rd_data_s), 32'h26);

    // Reset mid-frame.
    send_s(8'h30, 1'b0);
    check_eq("s_pre_rst_px", 32'(wr_px_s), 2);
    rst_s = 1'b1;
    @(posedge clk); #1;
    check_eq("s_mid_rst_ready", 32'(bus_s.byte_ready), 0);
    check_eq("s_mid_rst_px", 32'(wr_px_s), 0);
    check_eq("s_mid_rst_state", 32'(state_s), 0);
    check_eq("s_mid_rst_rd_data", 32'(rd_data_s), 0);
    check_eq("s_mid_rst_rd_valid", 32'(rd_valid_s), 0);
    rst_s = 1'b0;
    @(posedge clk); #1;
    send_s(8'h99, 1'b0);
    check_eq("s_post_rst_drop", 32'(wr_px_s), 0);
    rd_s(10'd1, 10'd0);
    check_eq("s_kept_1_0", 32'(rd_data_s), 32'h30);
    rd_s(10'd2, 10'd1);
    check_eq("s_kept_2_1", 32'(rd_data_s), 32'h26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
